// File: rtl/fp_operand_driver.sv
// fp_operand_driver: LFSR-driven operand initiator for the FP div/sqrt core.
// It drives operands A (and B) over stb/ack, accepts result Z, and reports
// each {a, b, z} triple with a result_valid pulse.
module fp_operand_driver #(
  parameter int               WIDTH = 64,
  parameter logic [WIDTH-1:0] TAPS  = 64'hD800000000000000,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic             two_operand,
  output logic [WIDTH-1:0] output_a,
  output logic             output_a_stb,
  input  logic             input_a_ack,
  output logic [WIDTH-1:0] output_b,
  output logic             output_b_stb,
  input  logic             input_b_ack,
  input  logic [WIDTH-1:0] input_z,
  input  logic             input_z_stb,
  output logic             output_z_ack,
  output logic [WIDTH-1:0] result_a,
  output logic [WIDTH-1:0] result_b,
  output logic [WIDTH-1:0] result_z,
  output logic             result_valid,
  output logic [CNT_W-1:0] op_count,
  output logic             busy,
  output logic             done
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [WIDTH-1:0] LP_SEED = (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_SEND, S_WAIT_Z, S_FIN
  } state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_lfsr, w_lfsr_next;
  logic [WIDTH-1:0] r_a, r_b, r_res_a, r_res_b, r_res_z;
  logic             r_a_stb, r_b_stb, r_z_ack, r_result_valid, r_busy, r_done;
  logic             r_two_op;
  logic [CNT_W-1:0] r_num_ops, r_op_count;
  logic             w_a_pend, w_b_pend, w_last;

  // Strobes still outstanding after this edge; a transfer clears its own strobe.
  assign w_a_pend    = r_a_stb & ~input_a_ack;
  assign w_b_pend    = r_b_stb & ~input_b_ack;
  assign w_last      = (CNT_W'(r_op_count + 1'b1) == r_num_ops);
  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = (num_ops == '0) ? S_FIN : S_LOAD_A;
      S_LOAD_A: w_next = r_two_op ? S_LOAD_B : S_SEND;
      S_LOAD_B: w_next = S_SEND;
      S_SEND:   if (!w_a_pend && !w_b_pend) w_next = S_WAIT_Z;
      S_WAIT_Z: if (input_z_stb) w_next = w_last ? S_FIN : S_LOAD_A;
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: operand generation, handshake strobes, result capture, status.
  // Every output is registered, so each state's action shows up the cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr         <= LP_SEED;
      r_a            <= '0;
      r_b            <= '0;
      r_res_a        <= '0;
      r_res_b        <= '0;
      r_res_z        <= '0;
      r_a_stb        <= 1'b0;
      r_b_stb        <= 1'b0;
      r_z_ack        <= 1'b0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_two_op       <= 1'b0;
      r_num_ops      <= '0;
      r_op_count     <= '0;
    end else begin
      r_result_valid <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_num_ops  <= num_ops;
          r_two_op   <= two_operand;
          r_op_count <= '0;
          r_busy     <= 1'b1;
        end
        S_LOAD_A: begin
          r_a    <= r_lfsr;
          r_lfsr <= w_lfsr_next;
          if (!r_two_op) begin
            r_b     <= '0;
            r_a_stb <= 1'b1;
          end
        end
        S_LOAD_B: begin
          r_b     <= r_lfsr;
          r_lfsr  <= w_lfsr_next;
          r_a_stb <= 1'b1;
          r_b_stb <= 1'b1;
        end
        S_SEND: begin
          if (input_a_ack) r_a_stb <= 1'b0;
          if (input_b_ack) r_b_stb <= 1'b0;
          if (!w_a_pend && !w_b_pend) r_z_ack <= 1'b1;
        end
        S_WAIT_Z: if (input_z_stb) begin
          r_res_a        <= r_a;
          r_res_b        <= r_b;
          r_res_z        <= input_z;
          r_result_valid <= 1'b1;
          r_op_count     <= CNT_W'(r_op_count + 1'b1);
          r_z_ack        <= 1'b0;
        end
        S_FIN: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign output_a     = r_a;
  assign output_a_stb = r_a_stb;
  assign output_b     = r_b;
  assign output_b_stb = r_b_stb;
  assign output_z_ack = r_z_ack;
  assign result_a     = r_res_a;
  assign result_b     = r_res_b;
  assign result_z     = r_res_z;
  assign result_valid = r_result_valid;
  assign op_count     = r_op_count;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule
